iir_mac_scheduler: RTL and testbench

- Control sequencer for a time-multiplexed cascaded-biquad IIR datapath: one shared multiplier, one accumulator, one coefficient ROM and per-section delay lines.
- Takes one AXIS sample from the ADC SPI front end and issues every multiply-accumulate for all second-order sections in a fixed order.
- Drives delay-line updates and presents the filtered result on an AXIS master.
- Contains no arithmetic; it drives only selects, enables and handshakes.

---
 rtl/iir_mac_scheduler.sv | 184 ++++++++++++++++++
 tb/tb_iir_mac_scheduler.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/iir_mac_scheduler.sv
// iir_mac_scheduler: control sequencer for a time-multiplexed cascaded-biquad
// IIR datapath. It accepts one sample, then issues TAPS multiplies for each
// section, waits for the multiplier pipeline to drain, and writes the
// section's delay line. After the last section it hands the result to the
// AXIS master. The block drives only selects, enables and handshakes; it
// contains no arithmetic on sample data.
`timescale 1ns/1ps

module iir_mac_scheduler #(
  parameter int NUM_SOS = 4,  // cascaded second-order sections (1..8)
  parameter int TAPS    = 5,  // multiplies per section: b0, b1, b2, a1, a2
  parameter int MUL_LAT = 2,  // mul_en to product-at-accumulator latency (1..4)
  parameter int COEF_AW = 6   // 2**COEF_AW >= NUM_SOS*TAPS
) (
  input  logic               clk,
  input  logic               rst,
  // ADC sample input
  input  logic               s_axis_tvalid,
  output logic               s_axis_tready,
  output logic               sample_load,
  // multiplier / coefficient ROM / operand mux
  output logic               mul_en,
  output logic [COEF_AW-1:0] coef_addr,
  output logic [2:0]         op_sel,
  output logic [2:0]         sos_idx,
  // accumulator
  output logic               acc_clr,
  output logic               acc_en,
  // delay lines
  output logic               state_wr,
  output logic               state_clr,
  // filtered output
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    WRITE = 2'd3
  } state_e;

  localparam logic [2:0] LAST_TAP  = 3'(TAPS - 1);
  localparam logic [2:0] LAST_SOS  = 3'(NUM_SOS - 1);
  localparam logic [2:0] LAST_WAIT = 3'(MUL_LAT - 1);

  state_e             state_q, state_d;
  logic [2:0]         tap_q, tap_d;      // current tap / operand within section
  logic [2:0]         sos_q, sos_d;      // current section
  logic [2:0]         wait_q, wait_d;    // cycles spent in WAIT
  logic               init_q, init_d;    // set by reset, cleared by first edge
  logic               clr_q, clr_d;      // one-cycle delay-line clear
  logic               tvalid_q, tvalid_d;
  logic [MUL_LAT-1:0] en_pipe_q, en_pipe_d;
  logic [MUL_LAT-1:0] first_pipe_q, first_pipe_d;
  logic               out_load;          // final-section write completes

  // Next-state logic, strobes and input handshake of the sequencer FSM.
  always_comb begin
    // NOTE: every signal written here gets a default first so that no path
    // through the case statement leaves it unassigned, which would infer a latch.
    state_d  = state_q;
    tap_d    = tap_q;
    sos_d    = sos_q;
    wait_d   = wait_q;
    mul_en   = 1'b0;
    state_wr = 1'b0;
    out_load = 1'b0;

    // The clear cycle and the cycle before it refuse samples so that no
    // sample is processed against stale delay lines.
    s_axis_tready = (state_q == IDLE) && !init_q && !clr_q;
    sample_load   = s_axis_tvalid && s_axis_tready;

    unique case (state_q)
      IDLE: begin
        if (sample_load) begin
          state_d = ISSUE;
          tap_d   = 3'd0;
          sos_d   = 3'd0;
        end
      end
      ISSUE: begin
        mul_en = 1'b1;
        if (tap_q == LAST_TAP) begin
          state_d = WAIT;
          wait_d  = 3'd0;
        end else begin
          tap_d = tap_q + 3'd1;
        end
      end
      WAIT: begin
        // The last product of the section reaches the accumulator in the
        // final WAIT cycle, so WRITE always sees a settled sum.
        if (wait_q == LAST_WAIT) begin
          state_d = WRITE;
        end else begin
          wait_d = wait_q + 3'd1;
        end
      end
      WRITE: begin
        if (sos_q != LAST_SOS) begin
          state_wr = 1'b1;
          sos_d    = sos_q + 3'd1;
          tap_d    = 3'd0;
          state_d  = ISSUE;
        end else if (!tvalid_q || m_axis_tready) begin
          // The output register is free (or being emptied this cycle), so
          // the final section may overwrite it. Otherwise hold everything.
          state_wr = 1'b1;
          out_load = 1'b1;
          sos_d    = 3'd0;
          tap_d    = 3'd0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output-valid flag, post-reset clear sequencing and accumulate pipelines.
  always_comb begin
    if (out_load) begin
      tvalid_d = 1'b1;
    end else if (tvalid_q && m_axis_tready) begin
      tvalid_d = 1'b0;
    end else begin
      tvalid_d = tvalid_q;
    end

    init_d = 1'b0;
    clr_d  = init_q;

    en_pipe_d       = en_pipe_q;
    first_pipe_d    = first_pipe_q;
    en_pipe_d[0]    = mul_en;
    first_pipe_d[0] = mul_en && (tap_q == 3'd0);
    for (int i = 1; i < MUL_LAT; i++) begin
      en_pipe_d[i]    = en_pipe_q[i-1];
      first_pipe_d[i] = first_pipe_q[i-1];
    end
  end

  // State register; all control state is cleared asynchronously on rst.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      // NOTE: the accumulate pipelines are reset along with the FSM so a
      // reset mid-run cannot leave a stray acc_en in flight.
      state_q      <= IDLE;
      tap_q        <= 3'd0;
      sos_q        <= 3'd0;
      wait_q       <= 3'd0;
      init_q       <= 1'b1;
      clr_q        <= 1'b0;
      tvalid_q     <= 1'b0;
      en_pipe_q    <= '0;
      first_pipe_q <= '0;
    end else begin
      state_q      <= state_d;
      tap_q        <= tap_d;
      sos_q        <= sos_d;
      wait_q       <= wait_d;
      init_q       <= init_d;
      clr_q        <= clr_d;
      tvalid_q     <= tvalid_d;
      en_pipe_q    <= en_pipe_d;
      first_pipe_q <= first_pipe_d;
    end
  end

  assign op_sel        = tap_q;
  assign sos_idx       = sos_q;
  assign coef_addr     = COEF_AW'(int'(sos_q) * TAPS + int'(tap_q));
  assign acc_en        = en_pipe_q[MUL_LAT-1];
  assign acc_clr       = first_pipe_q[MUL_LAT-1];
  assign state_clr     = clr_q;
  assign m_axis_tvalid = tvalid_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_iir_mac_scheduler.sv
// Testbench for iir_mac_scheduler. A cycle-level reference model derived
// from the schedule rules (offset since accept -> section/tap/write) predicts
// every output each cycle; stimulus mixes directed phases with random
// input valid / output ready patterns.
`timescale 1ns/1ps

module tb_iir_mac_scheduler;

  localparam int NUM_SOS = 4;
  localparam int TAPS    = 5;
  localparam int MUL_LAT = 2;
  localparam int COEF_AW = 6;
  localparam int PERIOD  = TAPS + MUL_LAT + 1;  // cycles per section
  localparam int RUN_LEN = NUM_SOS * PERIOD;    // accept -> last write offset

  logic               clk = 1'b0;
  logic               rst;
  logic               s_axis_tvalid;
  logic               s_axis_tready;
  logic               sample_load;
  logic               mul_en;
  logic [COEF_AW-1:0] coef_addr;
  logic [2:0]         op_sel;
  logic [2:0]         sos_idx;
  logic               acc_clr;
  logic               acc_en;
  logic               state_wr;
  logic               state_clr;
  logic               m_axis_tvalid;
  logic               m_axis_tready;
  logic               busy;

  always #5 clk = ~clk;

  iir_mac_scheduler #(
    .NUM_SOS (NUM_SOS),
    .TAPS    (TAPS),
    .MUL_LAT (MUL_LAT),
    .COEF_AW (COEF_AW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .sample_load   (sample_load),
    .mul_en        (mul_en),
    .coef_addr     (coef_addr),
    .op_sel        (op_sel),
    .sos_idx       (sos_idx),
    .acc_clr       (acc_clr),
    .acc_en        (acc_en),
    .state_wr      (state_wr),
    .state_clr     (state_clr),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .busy          (busy)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state.
  bit m_active;      // a sample is being processed
  int m_d;           // schedule offset since accept (frozen while stalled)
  bit m_tv;          // expected m_axis_tvalid
  int m_clr_phase;   // 1: waiting for first edge, 2: clear cycle, 0: done
  bit acc_hist[$];   // expected mul_en, MUL_LAT cycles deep
  bit first_hist[$]; // expected first-tap mul_en, MUL_LAT cycles deep
  int accept_cyc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_active    = 1'b0;
    m_d         = 0;
    m_tv        = 1'b0;
    m_clr_phase = 1;
    acc_hist    = {};
    first_hist  = {};
    for (int i = 0; i < MUL_LAT; i++) begin
      acc_hist.push_back(1'b0);
      first_hist.push_back(1'b0);
    end
  endtask

  // One clock cycle: drive inputs at the falling edge, check every output
  // against the model, then advance the model to the next cycle.
  task automatic step(input bit rst_in, input bit tv_in, input bit tr_in);
    bit e_tready, e_load, e_mul, e_first, e_wr, e_final, e_stall, e_acc, e_accclr;
    int e_op, e_sos, e_coef, k, r;
    @(negedge clk);
    rst           = rst_in;
    s_axis_tvalid = tv_in;
    m_axis_tready = tr_in;
    #1;
    if (rst_in) begin
      model_reset();
      check("rst_tready",   32'(s_axis_tready), 32'(0));
      check("rst_load",     32'(sample_load),   32'(0));
      check("rst_mul_en",   32'(mul_en),        32'(0));
      check("rst_coef",     32'(coef_addr),     32'(0));
      check("rst_op_sel",   32'(op_sel),        32'(0));
      check("rst_sos_idx",  32'(sos_idx),       32'(0));
      check("rst_acc_en",   32'(acc_en),        32'(0));
      check("rst_acc_clr",  32'(acc_clr),       32'(0));
      check("rst_state_wr", 32'(state_wr),      32'(0));
      check("rst_clr",      32'(state_clr),     32'(0));
      check("rst_tvalid",   32'(m_axis_tvalid), 32'(0));
      check("rst_busy",     32'(busy),          32'(0));
      return;
    end

    e_tready = !m_active && (m_clr_phase == 0);
    e_load   = tv_in && e_tready;
    e_mul = 0; e_first = 0; e_wr = 0; e_final = 0; e_stall = 0;
    e_op = 0; e_sos = 0; e_coef = 0;
    if (m_active) begin
      if (m_d >= RUN_LEN) begin
        e_final = 1;
        e_sos   = NUM_SOS - 1;
        e_coef  = NUM_SOS * TAPS - 1;
        e_stall = m_tv && !tr_in;
        e_wr    = !e_stall;
      end else begin
        k     = (m_d - 1) / PERIOD;
        r     = (m_d - 1) % PERIOD;
        e_sos = k;
        if (r < TAPS) begin
          e_mul   = 1;
          e_op    = r;
          e_coef  = k * TAPS + r;
          e_first = (r == 0);
        end else if (r == PERIOD - 1) begin
          e_wr = 1;
        end
      end
    end
    e_acc    = acc_hist.pop_front();
    e_accclr = first_hist.pop_front();
    acc_hist.push_back(e_mul);
    first_hist.push_back(e_first);

    check("s_axis_tready", 32'(s_axis_tready), 32'(e_tready));
    check("sample_load",   32'(sample_load),   32'(e_load));
    check("mul_en",        32'(mul_en),        32'(e_mul));
    check("state_wr",      32'(state_wr),      32'(e_wr));
    check("acc_en",        32'(acc_en),        32'(e_acc));
    check("acc_clr",       32'(acc_clr),       32'(e_accclr));
    check("m_axis_tvalid", 32'(m_axis_tvalid), 32'(m_tv));
    check("busy",          32'(busy),          32'(m_active));
    check("state_clr",     32'(state_clr),     32'(m_clr_phase == 2));
    if (e_mul) begin
      check("op_sel",    32'(op_sel),    32'(e_op));
      check("coef_addr", 32'(coef_addr), 32'(e_coef));
      check("sos_idx",   32'(sos_idx),   32'(e_sos));
    end
    if (e_wr || e_stall) check("wr_sos_idx", 32'(sos_idx), 32'(e_sos));
    if (e_stall) check("stall_coef_addr", 32'(coef_addr), 32'(e_coef));
    if (m_clr_phase == 2) begin
      check("clr_coef",    32'(coef_addr), 32'(0));
      check("clr_op_sel",  32'(op_sel),    32'(0));
      check("clr_sos_idx", 32'(sos_idx),   32'(0));
    end

    // Advance the model across the coming rising edge.
    if (m_clr_phase == 2) m_clr_phase = 0;
    else if (m_clr_phase == 1) m_clr_phase = 2;
    if (e_final && e_wr) begin
      m_tv     = 1'b1;
      m_active = 1'b0;
    end else if (m_tv && tr_in) begin
      m_tv = 1'b0;
    end
    if (e_load) begin
      m_active   = 1'b1;
      m_d        = 1;
      accept_cyc = cyc;
    end else if (m_active && !e_final) begin
      m_d++;
    end
  endtask

  // Accept one sample with the output always ready and measure the
  // accept-to-valid latency.
  task automatic single_run(input string tag);
    int n;
    step(0, 1, 1);
    check({tag, "_accepted"}, 32'(m_active), 32'(1));
    n = 0;
    while (!m_axis_tvalid && n < 4 * RUN_LEN) begin
      step(0, 0, 1);
      n++;
    end
    check({tag, "_latency"}, 32'(cyc - accept_cyc), 32'(RUN_LEN + 1));
    step(0, 0, 1);
    check({tag, "_tvalid_one_cycle"}, 32'(m_axis_tvalid), 32'(0));
  endtask

  initial begin
    rst           = 1'b1;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b0;

    // Reset and release: one clear cycle, then ready.
    repeat (3) step(1, 0, 0);
    step(0, 1, 1);
    step(0, 1, 1);
    check("post_clr_tready", 32'(s_axis_tready), 32'(0));
    step(0, 0, 1);
    check("ready_after_clr", 32'(s_axis_tready), 32'(1));

    // Single sample, full schedule.
    single_run("single");
    repeat (3) step(0, 0, 1);

    // Output held off, input held valid: two back-to-back runs, the second
    // stalls at its final write until the output is consumed.
    repeat (2 * RUN_LEN + 10) step(0, 1, 0);
    check("stall_active", 32'(m_active), 32'(1));
    repeat (RUN_LEN + 10) step(0, 0, 1);

    // Random input valid / output ready.
    for (int i = 0; i < 600; i++) begin
      step(0, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
    end
    repeat (2 * RUN_LEN + 4) step(0, 0, 1);

    // Reset in the middle of section 1, then a clean full run.
    step(0, 1, 1);
    repeat (13) step(0, 1, 1);
    repeat (2) step(1, 1, 1);
    step(0, 0, 1);
    step(0, 0, 1);
    step(0, 0, 1);
    single_run("after_reset");
    repeat (3) step(0, 0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
